// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running h/v counters gated by a pixel tick enable,
// producing registered sync, position, active-video and line/frame strobes.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10
) (
  input  logic           pixel_clk,
  input  logic           rst,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]     frame_cnt
`endif
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);

  // Counters must be able to hold TOTAL-1 without overflow.
  if ((longint'(H_TOTAL) > (longint'(1) << X_W)) ||
      (longint'(V_TOTAL) > (longint'(1) << Y_W))) begin : g_param_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the X_W/Y_W counter range");
  end

  // h_cnt/v_cnt hold the position that the next ce tick will present.
  logic [X_W-1:0] h_cnt, h_cnt_d;
  logic [Y_W-1:0] v_cnt, v_cnt_d;
  logic [31:0]    h_ext, v_ext;
  logic           h_sync_act, v_sync_act, active, at_origin, at_line_start;

  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  // Position decode of the counter value about to be presented.
  always_comb begin
    h_sync_act    = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
    v_sync_act    = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
    active        = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    at_line_start = (h_cnt == '0);
    at_origin     = at_line_start && (v_cnt == '0);
  end

  // Next-position: h wraps at H_TOTAL-1 and carries into v, which wraps at V_TOTAL-1.
  always_comb begin
    h_cnt_d = h_cnt + 1'b1;
    v_cnt_d = v_cnt;
    if (h_cnt == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  // Counters and registered outputs; strobes only fire on ce ticks.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        h_cnt       <= h_cnt_d;
        v_cnt       <= v_cnt_d;
        x_pos       <= h_cnt;
        y_pos       <= v_cnt;
        video_on    <= active;
        hsync       <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
        line_start  <= at_line_start;
        frame_start <= at_origin;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // The frame begun by reset is frame 0, so the first frame_start after reset
  // does not count; every later frame_start edge increments.
  logic started_q;

  // Frame counter, advanced on the edge that raises frame_start.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      started_q <= 1'b0;
    end else if (ce) begin
      started_q <= 1'b1;
      if (at_origin && started_q) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter DUT and a tiny positive-sync DUT
// run in lockstep; a scoreboard checks every cycle, plus a segment table and
// targeted sequences for periods, sync windows, wraps and the frame counter.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;

  logic       hs0, vs0, vid0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vid1, ls1, fs1;
  logic [3:0] x1, y1;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc0, fc1;
`endif

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen dut0 (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .ce         (ce),
    .hsync      (hs0),
    .vsync      (vs0),
    .x_pos      (x0),
    .y_pos      (y0),
    .video_on   (vid0),
    .line_start (ls0),
    .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .X_W(4), .Y_W(4)
  ) dut1 (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .ce         (ce),
    .hsync      (hs1),
    .vsync      (vs1),
    .x_pos      (x1),
    .y_pos      (y1),
    .video_on   (vid1),
    .line_start (ls1),
    .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fc1)
`endif
  );

  typedef struct {
    int x; int y; bit vid; bit hs; bit vs; bit ls; bit fs; int fc;
  } out_t;
  typedef struct {
    int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp; bit hpol; bit vpol;
  } cfg_t;
  typedef struct {
    bit r; int div; int n; int x; int y; bit vid; bit hs; bit ls; bit fs;
  } seg_t;

  cfg_t cfg[2];
  int   mh[2], mv[2], mfc[2];
  bit   mstart[2];
  out_t last[2];
  out_t q0[$], q1[$];
  int   checks = 0, errors = 0, cyc = 0;

  function automatic out_t reset_out(int d);
    out_t o;
    o.x = 0; o.y = 0; o.vid = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.fc = 0;
    o.hs = !cfg[d].hpol;
    o.vs = !cfg[d].vpol;
    return o;
  endfunction

  // Reference model: predicts the outputs after the coming edge and queues them.
  task automatic model_push(input int d, input bit c, input bit r);
    out_t o;
    int htot, vtot, hsb, vsb;
    htot = cfg[d].ha + cfg[d].hfp + cfg[d].hsw + cfg[d].hbp;
    vtot = cfg[d].va + cfg[d].vfp + cfg[d].vsw + cfg[d].vbp;
    hsb  = cfg[d].ha + cfg[d].hfp;
    vsb  = cfg[d].va + cfg[d].vfp;
    if (r) begin
      mh[d] = 0; mv[d] = 0; mfc[d] = 0; mstart[d] = 1'b0;
      o = reset_out(d);
    end else if (c) begin
      o.x   = mh[d];
      o.y   = mv[d];
      o.vid = (mh[d] < cfg[d].ha) && (mv[d] < cfg[d].va);
      o.hs  = (mh[d] >= hsb && mh[d] < hsb + cfg[d].hsw) ? cfg[d].hpol : !cfg[d].hpol;
      o.vs  = (mv[d] >= vsb && mv[d] < vsb + cfg[d].vsw) ? cfg[d].vpol : !cfg[d].vpol;
      o.ls  = (mh[d] == 0);
      o.fs  = (mh[d] == 0) && (mv[d] == 0);
      if (o.fs && mstart[d]) mfc[d] = (mfc[d] + 1) % 256;
      mstart[d] = 1'b1;
      o.fc  = mfc[d];
      mh[d] = mh[d] + 1;
      if (mh[d] == htot) begin
        mh[d] = 0;
        mv[d] = (mv[d] + 1) % vtot;
      end
    end else begin
      o = last[d];
      o.ls = 1'b0;
      o.fs = 1'b0;
    end
    last[d] = o;
    if (d == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  function automatic out_t dut_out(int d);
    out_t o;
    o.fc = 0;
    if (d == 0) begin
      o.x = int'(x0); o.y = int'(y0); o.vid = vid0; o.hs = hs0; o.vs = vs0;
      o.ls = ls0; o.fs = fs0;
`ifdef VGA_FRAME_CNT_EN
      o.fc = int'(fc0);
`endif
    end else begin
      o.x = int'(x1); o.y = int'(y1); o.vid = vid1; o.hs = hs1; o.vs = vs1;
      o.ls = ls1; o.fs = fs1;
`ifdef VGA_FRAME_CNT_EN
      o.fc = int'(fc1);
`endif
    end
    return o;
  endfunction

  task automatic sb_check(input int d);
    out_t e, a;
    bit   bad;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL sb dut%0d cyc %0d: scoreboard queue empty", d, cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    a = dut_out(d);
    bad = (a.x != e.x) || (a.y != e.y) || (a.vid != e.vid) || (a.hs != e.hs) ||
          (a.vs != e.vs) || (a.ls != e.ls) || (a.fs != e.fs);
`ifdef VGA_FRAME_CNT_EN
    bad = bad || (a.fc != e.fc);
`endif
    if (bad) begin
      errors++;
      $display("FAIL sb dut%0d cyc %0d: got x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, want x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
               d, cyc, a.x, a.y, a.vid, a.hs, a.vs, a.ls, a.fs, a.fc,
               e.x, e.y, e.vid, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, queue predictions, sample 1 time unit after the edge.
  task automatic step(input bit c, input bit r);
    ce  = c;
    rst = r;
    model_push(0, c, r);
    model_push(1, c, r);
    @(posedge pixel_clk);
    #1;
    cyc++;
    sb_check(0);
    sb_check(1);
  endtask

  seg_t segs[9];

  initial begin
    int last_ls, per, nls, hmin, hmax, hcnt, von, run, maxrun;
    int xmax, ymax, hsmin, hsmax, vsmin, vsmax, nfs, last_fs, fper;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};

    //         r     div  n     x    y  vid   hs    ls    fs
    segs[0] = '{1'b1, 1,   3,    0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[1] = '{1'b0, 1,   1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    segs[2] = '{1'b0, 1,   700,  700, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    segs[3] = '{1'b0, 1,   100,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
    segs[4] = '{1'b0, 4,   3200, 0,   2, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[5] = '{1'b0, 0,   50,   0,   2, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[6] = '{1'b0, 1,   300,  300, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[7] = '{1'b1, 1,   1,    0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[8] = '{1'b0, 1,   1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int s = 0; s < 9; s++) begin
      for (int i = 0; i < segs[s].n; i++) begin
        step(segs[s].div != 0 && (i % segs[s].div) == 0, segs[s].r);
      end
      chk($sformatf("seg%0d x", s), int'(x0), segs[s].x);
      chk($sformatf("seg%0d y", s), int'(y0), segs[s].y);
      chk($sformatf("seg%0d video_on", s), int'(vid0), int'(segs[s].vid));
      chk($sformatf("seg%0d hsync", s), int'(hs0), int'(segs[s].hs));
      chk($sformatf("seg%0d line_start", s), int'(ls0), int'(segs[s].ls));
      chk($sformatf("seg%0d frame_start", s), int'(fs0), int'(segs[s].fs));
    end

    // Full rate: line period, hsync window and active width on line y=1.
    last_ls = cyc; per = 0; nls = 0; hmin = 9999; hmax = -1; hcnt = 0; von = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1, 1'b0);
      if (ls0) begin per = cyc - last_ls; last_ls = cyc; nls++; end
      if (y0 == 10'd1) begin
        if (!hs0) begin
          hcnt++;
          if (int'(x0) < hmin) hmin = int'(x0);
          if (int'(x0) > hmax) hmax = int'(x0);
        end
        if (vid0) von++;
      end
    end
    chk("full-rate line_start count", nls, 2);
    chk("full-rate line period", per, 800);
    chk("hsync low first x", hmin, 656);
    chk("hsync low last x", hmax, 751);
    chk("hsync low width", hcnt, 96);
    chk("video_on width", von, 640);

    // Quarter rate: 3200-cycle line period, single-cycle strobes.
    nls = 0; per = 0; last_ls = -1; run = 0; maxrun = 0;
    for (int i = 0; i < 6400; i++) begin
      step((i % 4) == 0, 1'b0);
      if (ls0) begin
        run++;
        if (run > maxrun) maxrun = run;
        if (last_ls >= 0) per = cyc - last_ls;
        last_ls = cyc;
        nls++;
      end else begin
        run = 0;
      end
    end
    chk("quarter-rate line_start count", nls, 2);
    chk("quarter-rate line period", per, 3200);
    chk("quarter-rate strobe width", maxrun, 1);

    // Small config: wraps, positive sync windows, frame period.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    xmax = -1; ymax = -1; hsmin = 99; hsmax = -1; vsmin = 99; vsmax = -1;
    nfs = 0; last_fs = -1; fper = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0);
      if (int'(x1) > xmax) xmax = int'(x1);
      if (int'(y1) > ymax) ymax = int'(y1);
      if (hs1) begin
        if (int'(x1) < hsmin) hsmin = int'(x1);
        if (int'(x1) > hsmax) hsmax = int'(x1);
      end
      if (vs1) begin
        if (int'(y1) < vsmin) vsmin = int'(y1);
        if (int'(y1) > vsmax) vsmax = int'(y1);
      end
      if (fs1) begin
        if (last_fs >= 0) fper = cyc - last_fs;
        last_fs = cyc;
        nfs++;
      end
    end
    chk("small x max", xmax, 13);
    chk("small y max", ymax, 6);
    chk("small hsync high first x", hsmin, 10);
    chk("small hsync high last x", hsmax, 11);
    chk("small vsync high first y", vsmin, 5);
    chk("small vsync high last y", vsmax, 5);
    chk("small frame_start count", nfs, 4);
    chk("small frame period", fper, 98);

`ifdef VGA_FRAME_CNT_EN
    // Frame counter over 257 frame starts on the small config.
    step(1'b1, 1'b1);
    chk("frame_cnt after reset", int'(fc1), 0);
    nfs = 0;
    for (int i = 0; i < 26000 && nfs < 257; i++) begin
      step(1'b1, 1'b0);
      if (fs1) begin
        nfs++;
        if (nfs == 1) chk("frame_cnt at first frame_start", int'(fc1), 0);
        if (nfs == 2) chk("frame_cnt at second frame_start", int'(fc1), 1);
        if (nfs == 257) chk("frame_cnt after 256 frames", int'(fc1), 0);
      end
    end
    chk("frame_cnt frames reached", nfs, 257);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, giving horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33, giving vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters H_SYNC_POL 0 and V_SYNC_POL 0, giving the sync active level (0 = active-low).
REQ-006 SHALL have parameters X_W 10 and Y_W 10, giving the position output widths.
REQ-007 SHALL have ports pixel_clk (input, 1, sole clock, rising edge) and rst (input, 1, synchronous active-high reset).
REQ-008 SHALL have ports ce (input, 1, pixel tick enable) and hsync, vsync (outputs, 1, sync at the configured polarity).
REQ-009 SHALL have ports x_pos (output, X_W, horizontal position 0..H_TOTAL-1) and y_pos (output, Y_W, vertical position 0..V_TOTAL-1).
REQ-010 SHALL have ports video_on (output, 1, position inside the active area), line_start (output, 1, strobe) and frame_start (output, 1, strobe).

Function
REQ-011 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; these are 800 and 525 by default.
REQ-012 SHALL keep internal next-position counters h_cnt and v_cnt, advancing only on clock edges where ce=1; ce=0 holds all counters and all non-strobe outputs.
REQ-013 SHALL increment h_cnt on each ce tick and wrap it from H_TOTAL-1 to 0; on that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
REQ-014 SHALL register all outputs: on a ce tick, outputs present the position held in the counters before that edge, so the first ce tick after reset presents (0,0).
REQ-015 SHALL drive video_on = 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-016 SHALL drive hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and vsync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
REQ-017 SHALL assert line_start for exactly one pixel_clk cycle when the presented x becomes 0.
REQ-018 SHALL assert frame_start for exactly one pixel_clk cycle when the presented (x,y) becomes (0,0); line_start is also high that cycle.
REQ-019 SHALL hold line_start and frame_start at 0 on cycles with ce=0, regardless of the ce duty cycle.
REQ-020 SHALL require H_TOTAL <= 2^X_W and V_TOTAL <= 2^Y_W; the counters SHALL use exactly X_W and Y_W bits, with no overflow past TOTAL-1.
REQ-021 SHALL treat ce held at 1 continuously as full-rate operation; with ce=1 every fourth cycle, it generates 25 MHz timing from a 100 MHz pixel_clk.

Reset
REQ-022 SHALL, on the clock edge where rst=1, clear h_cnt, v_cnt, x_pos and y_pos to 0 and clear video_on, line_start and frame_start to 0.
REQ-023 SHALL, in that same reset edge, drive hsync to ~H_SYNC_POL and vsync to ~V_SYNC_POL (the inactive levels).
REQ-024 SHALL give rst priority over ce; rst mid-frame aborts the frame, and the next ce tick after release presents (0,0) with frame_start=1.

Configuration
REQ-025 SHALL support macro VGA_FRAME_CNT_EN; when defined, an extra output frame_cnt [7:0] exists, resets to 0, and increments modulo 256 on the clock edge that asserts frame_start.
REQ-026 SHALL omit the frame_cnt port and logic entirely when VGA_FRAME_CNT_EN is undefined; all other behaviour is identical in both builds.

Verification
REQ-027 Default parameters, ce=1, release rst -> first cycle x=0, y=0, video_on=1, frame_start=1, line_start=1; line_start recurs every 800 cycles; frame_start recurs every 420000 cycles.
REQ-028 Default parameters -> hsync=0 exactly for x 656..751 and vsync=0 exactly for y 490..491; video_on=0 for x>=640 or y>=480.
REQ-029 ce=1 every 4th cycle -> x advances by 1 per 4 cycles; strobes are 1 cycle wide; line period is 3200 cycles.
REQ-030 Assert rst at x=300, y=200 -> next edge gives all outputs at reset values; the first ce tick after release gives (0,0) with frame_start=1.
REQ-031 Set H_SYNC_POL=1, V_SYNC_POL=1 with H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, X_W=Y_W=4 -> hsync=1 for x 10..11; x wraps at 13; y wraps at 6.
REQ-032 Build with VGA_FRAME_CNT_EN and ce=1 -> frame_cnt=0 after reset, 1 at the second frame_start, and returns to 0 after 256 frames.
